// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day keeper: mode encodings, field limits
// and the wrap-around increment used by both the set keys and the carry chain.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    // >= rather than == so an out-of-range value can never keep climbing.
    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
        return (val >= max_val) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button path: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press (debounced level going 1 -> 0).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    logic w_differ;
    logic w_accept;

    assign w_differ = (r_sync2 != r_level);
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: synchronizer resets to the released level so reset exit never looks like a press.
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= w_accept && !r_sync2;
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/clock_time_keeper.sv
// 24-hour time-of-day counter with a 1 Hz prescaler and a two-key setting FSM;
// feeds hour/min/sec to the analog-clock renderer.
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [5:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       tick_1s,
    output logic [1:0] mode
);

    localparam int            PW         = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    logic [PW-1:0] r_presc;
    logic [5:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic          r_tick;
    mode_e         r_mode;

    mode_e         w_mode_next;
    logic          w_mode_evt;
    logic          w_inc_evt;
    logic          w_count_en;
    logic          w_tc;
    logic [PW-1:0] w_presc_next;
    logic [5:0]    w_hour_next;
    logic [5:0]    w_min_next;
    logic [5:0]    w_sec_next;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_mode (
        .clk  (clk),
        .reset(reset),
        .key_n(key_mode),
        .press(w_mode_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_inc (
        .clk  (clk),
        .reset(reset),
        .key_n(key_inc),
        .press(w_inc_evt)
    );

    assign w_count_en = (r_mode == MODE_RUN) && clken;
    assign w_tc       = w_count_en && (r_presc == PRESC_LAST);

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_mode_next = r_mode;
        if (w_mode_evt) begin
            case (r_mode)
                MODE_RUN:      w_mode_next = MODE_SET_HOUR;
                MODE_SET_HOUR: w_mode_next = MODE_SET_MIN;
                MODE_SET_MIN:  w_mode_next = MODE_SET_SEC;
                MODE_SET_SEC:  w_mode_next = MODE_RUN;
                default:       w_mode_next = MODE_RUN;
            endcase
        end
    end

    // Counting and key increments are exclusive: counting only happens in RUN,
    // where increments are ignored.
    always_comb begin
        w_presc_next = r_presc;
        w_hour_next  = r_hour;
        w_min_next   = r_min;
        w_sec_next   = r_sec;
        if (w_count_en) begin
            if (w_tc) begin
                w_presc_next = '0;
                w_sec_next   = wrap_inc(r_sec, SEC_MAX);
                if (r_sec >= SEC_MAX) begin
                    w_min_next = wrap_inc(r_min, MIN_MAX);
                    if (r_min >= MIN_MAX) begin
                        w_hour_next = wrap_inc(r_hour, HOUR_MAX);
                    end
                end
            end else begin
                w_presc_next = r_presc + PW'(1);
            end
        end else if (w_inc_evt) begin
            case (r_mode)
                MODE_SET_HOUR: w_hour_next = wrap_inc(r_hour, HOUR_MAX);
                MODE_SET_MIN:  w_min_next  = wrap_inc(r_min, MIN_MAX);
                MODE_SET_SEC: begin
                    w_sec_next   = '0;
                    w_presc_next = '0;
                end
                default: ;
            endcase
        end
        // Returning to RUN restarts the second so the first tick is a full period away.
        if (w_mode_evt && (r_mode == MODE_SET_SEC)) begin
            w_presc_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= MODE_RUN;
            r_presc <= '0;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_mode  <= w_mode_next;
            r_presc <= w_presc_next;
            r_hour  <= w_hour_next;
            r_min   <= w_min_next;
            r_sec   <= w_sec_next;
            r_tick  <= w_tc;
        end
    end

    assign hour    = r_hour;
    assign min     = r_min;
    assign sec     = r_sec;
    assign tick_1s = r_tick;
    assign mode    = r_mode;

endmodule
